// File: rtl/rom_dpll_if.sv
// ---------------------------------------------------------------------------
// rom_dpll_if
// Purpose : bundles the lookup bus of the FDC data-separator phase table.
//           The parent (master) presents the 6-bit table address and reads
//           back the registered 5-bit next phase count.
// Signals :
//   address [5:0] - [5] = 1 no data pulse this cycle, 0 pulse present;
//                   [4:0] = current phase count
//   q       [4:0] - registered next phase count
// Modports:
//   master - drives address, observes q (the PLL parent / testbench)
//   slave  - observes address, drives q (rom_dpll)
// ---------------------------------------------------------------------------
interface rom_dpll_if;
  logic [5:0] address;
  logic [4:0] q;

  modport master (output address, input q);
  modport slave  (input address, output q);
endinterface

// File: rtl/rom_dpll.sv
// ---------------------------------------------------------------------------
// rom_dpll
// Purpose : registered 64x5 lookup table holding the next-state function of
//           the floppy read-data phase-locked loop (WD1793-style data
//           separator). The parent feeds q back into address[4:0] and toggles
//           RCLK whenever q reaches 16, so a free-running count gives one
//           RCLK toggle every 32 clocks. A data pulse pulls the count halfway
//           toward the window centre (count 0).
// Ports   :
//   clock   - rising-edge clock, sole clock domain
//   reset_n - synchronous reset, active-low, forces q to 0
//   bus     - rom_dpll_if.slave: address in, q out
// ---------------------------------------------------------------------------
module rom_dpll (
  input  logic       clock,
  input  logic       reset_n,
  rom_dpll_if.slave  bus
);

  logic [4:0] w_next;
  logic [4:0] r_q;

  // Table content. Upper half (address[5]=1) just advances the phase by one
  // with wrap. Lower half applies a pulse correction: with s the signed view
  // of the count and e = s/2 truncated toward zero, next = c + 1 - e, which
  // halves the phase error at every pulse. Stored as literal content so the
  // table reads exactly like the original ROM image.
  always_comb begin
    w_next = 5'd0;
    case (bus.address)
      // pulse present, count 0..15 (pulse arrived late)
      6'h00: w_next = 5'd1;
      6'h01: w_next = 5'd2;
      6'h02: w_next = 5'd2;
      6'h03: w_next = 5'd3;
      6'h04: w_next = 5'd3;
      6'h05: w_next = 5'd4;
      6'h06: w_next = 5'd4;
      6'h07: w_next = 5'd5;
      6'h08: w_next = 5'd5;
      6'h09: w_next = 5'd6;
      6'h0A: w_next = 5'd6;
      6'h0B: w_next = 5'd7;
      6'h0C: w_next = 5'd7;
      6'h0D: w_next = 5'd8;
      6'h0E: w_next = 5'd8;
      6'h0F: w_next = 5'd9;
      // pulse present, count 16..31 (pulse arrived early, s = c - 32)
      6'h10: w_next = 5'd25;
      6'h11: w_next = 5'd25;
      6'h12: w_next = 5'd26;
      6'h13: w_next = 5'd26;
      6'h14: w_next = 5'd27;
      6'h15: w_next = 5'd27;
      6'h16: w_next = 5'd28;
      6'h17: w_next = 5'd28;
      6'h18: w_next = 5'd29;
      6'h19: w_next = 5'd29;
      6'h1A: w_next = 5'd30;
      6'h1B: w_next = 5'd30;
      6'h1C: w_next = 5'd31;
      6'h1D: w_next = 5'd31;
      6'h1E: w_next = 5'd0;
      6'h1F: w_next = 5'd0;
      // no pulse: free-running increment with wrap 31 -> 0
      6'h20: w_next = 5'd1;
      6'h21: w_next = 5'd2;
      6'h22: w_next = 5'd3;
      6'h23: w_next = 5'd4;
      6'h24: w_next = 5'd5;
      6'h25: w_next = 5'd6;
      6'h26: w_next = 5'd7;
      6'h27: w_next = 5'd8;
      6'h28: w_next = 5'd9;
      6'h29: w_next = 5'd10;
      6'h2A: w_next = 5'd11;
      6'h2B: w_next = 5'd12;
      6'h2C: w_next = 5'd13;
      6'h2D: w_next = 5'd14;
      6'h2E: w_next = 5'd15;
      6'h2F: w_next = 5'd16;
      6'h30: w_next = 5'd17;
      6'h31: w_next = 5'd18;
      6'h32: w_next = 5'd19;
      6'h33: w_next = 5'd20;
      6'h34: w_next = 5'd21;
      6'h35: w_next = 5'd22;
      6'h36: w_next = 5'd23;
      6'h37: w_next = 5'd24;
      6'h38: w_next = 5'd25;
      6'h39: w_next = 5'd26;
      6'h3A: w_next = 5'd27;
      6'h3B: w_next = 5'd28;
      6'h3C: w_next = 5'd29;
      6'h3D: w_next = 5'd30;
      6'h3E: w_next = 5'd31;
      6'h3F: w_next = 5'd0;
      default: w_next = 5'd0;
    endcase
  end

  // Output register. Reset wins over the lookup so a mid-run reset always
  // restarts the loop from the window centre.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_q <= 5'd0;
    end else begin
      r_q <= w_next;
    end
  end

  assign bus.q = r_q;

endmodule

// File: tb/tb_rom_dpll.sv
// ---------------------------------------------------------------------------
// tb_rom_dpll
// Purpose : self-checking bench for rom_dpll. Expected values come from a
//           reference function that evaluates the phase rules with plain
//           integer arithmetic; random stimulus is mixed with directed
//           closed-loop scenarios.
// ---------------------------------------------------------------------------
module tb_rom_dpll;

  logic clock;
  logic resetN;
  int   compareCount;
  int   mismatchCount;

  rom_dpll_if busIf ();

  rom_dpll dut (
    .clock   (clock),
    .reset_n (resetN),
    .bus     (busIf.slave)
  );

  // 10 time-unit clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference next-count function built straight from the phase rules.
  function automatic int refNext(input int addr);
    int c;
    int s;
    int e;
    int t;
    c = addr % 32;
    if (addr >= 32) begin
      t = c + 1;
    end else begin
      s = (c <= 15) ? c : c - 32;
      e = s / 2;
      t = c + 1 - e;
    end
    return ((t % 32) + 32) % 32;
  endfunction

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, let the rising edge
  // happen, then settle before the caller samples q.
  task automatic applyStimulus(input logic [5:0] addr, input logic rstn);
    @(negedge clock);
    busIf.address = addr;
    resetN        = rstn;
    @(posedge clock);
    #1;
  endtask

  // Free-run the loop until q reaches the target count (bounded).
  task automatic runToCount(input int target);
    int n;
    n = 0;
    while (int'(busIf.q) != target && n < 64) begin
      applyStimulus({1'b1, busIf.q}, 1'b1);
      n++;
    end
    checkOutput("reachCount", int'(busIf.q), target);
  endtask

  int modelQ;
  int seen16;
  int expect16;
  int pulseCount;
  int expectSeq[$];
  logic [5:0] sweepOrder[64];
  logic [5:0] tmpAddr;
  logic [5:0] rAddr;
  logic       rRst;

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    resetN        = 1'b0;
    busIf.address = 6'h3F;

    // Reset holds q at 0 even with the wrapping address present
    applyStimulus(6'h3F, 1'b0);
    checkOutput("resetEdge1", int'(busIf.q), 0);
    applyStimulus(6'h3F, 1'b0);
    checkOutput("resetEdge2", int'(busIf.q), 0);
    applyStimulus(6'h20, 1'b1);
    checkOutput("releaseLookup", int'(busIf.q), 1);

    // Free-running loop from 0 for 40 clocks
    applyStimulus(6'h3F, 1'b0);
    checkOutput("resetBeforeRun", int'(busIf.q), 0);
    modelQ   = 0;
    seen16   = 0;
    expect16 = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus({1'b1, busIf.q}, 1'b1);
      modelQ = (modelQ + 1) % 32;
      if (i < 32 && modelQ == 16) expect16++;
      if (i < 32 && busIf.q == 5'd16) seen16++;
      checkOutput($sformatf("freeRun%0d", i), int'(busIf.q), modelQ);
    end
    checkOutput("rclkTogglesPer32", seen16, expect16);

    // Exhaustive sweep in a random order
    for (int i = 0; i < 64; i++) sweepOrder[i] = 6'(i);
    for (int i = 63; i > 0; i--) begin
      int j;
      j = $urandom_range(0, i);
      tmpAddr       = sweepOrder[i];
      sweepOrder[i] = sweepOrder[j];
      sweepOrder[j] = tmpAddr;
    end
    for (int i = 0; i < 64; i++) begin
      applyStimulus(sweepOrder[i], 1'b1);
      checkOutput($sformatf("table_%02h", sweepOrder[i]), int'(busIf.q), refNext(int'(sweepOrder[i])));
    end

    // Hand-derived spot values
    applyStimulus(6'h3F, 1'b1); checkOutput("spot3F", int'(busIf.q), 0);
    applyStimulus(6'h04, 1'b1); checkOutput("spot04", int'(busIf.q), 3);
    applyStimulus(6'h0F, 1'b1); checkOutput("spot0F", int'(busIf.q), 9);
    applyStimulus(6'h10, 1'b1); checkOutput("spot10", int'(busIf.q), 25);
    applyStimulus(6'h1C, 1'b1); checkOutput("spot1C", int'(busIf.q), 31);
    applyStimulus(6'h1F, 1'b1); checkOutput("spot1F", int'(busIf.q), 0);

    // Random addresses with occasional reset
    for (int i = 0; i < 300; i++) begin
      rAddr = 6'($urandom);
      rRst  = ($urandom_range(0, 15) != 0);
      applyStimulus(rAddr, rRst);
      checkOutput($sformatf("rand%0d", i), int'(busIf.q), rRst ? refNext(int'(rAddr)) : 0);
    end

    // Lock convergence: late pulse first seen at count 12, then one pulse
    // every 32 clocks (pulse edge plus 31 free-running edges)
    applyStimulus(6'h00, 1'b0);
    runToCount(12);
    expectSeq.delete();
    modelQ = 12;
    for (int p = 0; p < 6; p++) begin
      expectSeq.push_back(modelQ);
      modelQ = refNext(modelQ);
      for (int k = 0; k < 31; k++) modelQ = refNext(32 + modelQ);
    end
    for (int p = 0; p < 6; p++) begin
      checkOutput($sformatf("lockAtPulse%0d", p), int'(busIf.q), expectSeq[p]);
      applyStimulus({1'b0, busIf.q}, 1'b1);
      if (p == 0) checkOutput("lateCorrection12", int'(busIf.q), 7);
      for (int k = 0; k < 31; k++) applyStimulus({1'b1, busIf.q}, 1'b1);
    end
    pulseCount = expectSeq[5];
    checkOutput("lockSteady", int'(busIf.q), pulseCount);

    // Early pulse at count 20 is pulled back toward the centre
    runToCount(20);
    applyStimulus({1'b0, busIf.q}, 1'b1);
    checkOutput("earlyCorrection20", int'(busIf.q), 27);

    // Mid-run reset at count 23
    runToCount(23);
    applyStimulus({1'b1, busIf.q}, 1'b0);
    checkOutput("midRunReset", int'(busIf.q), 0);
    applyStimulus(6'h00, 1'b1);
    checkOutput("afterMidReset", int'(busIf.q), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  // Hard time limit so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no finish, expected finish before limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
